tbpm_traceback: RTL

Parametrised traceback path memory with built-in traceback for the Viterbi decoder. It stores one decision vector per trellis step (one bit per state) into a TB_DEPTH-deep register file. Once a block of TB_DEPTH vectors is stored, an FSM walks the survivor path back from a supplied best state and emits one decoded bit per step. It sits between the ACS array and the output bit sink, and replaces the fixed 4-state shift-register path memory.

---
 rtl/tbpm_traceback.sv | 94 +++++++++
 1 files changed

// File: rtl/tbpm_traceback.sv
// Traceback path memory for the Viterbi decoder: stores TB_DEPTH decision vectors,
// then walks the survivor path back from best_state, emitting one decoded bit per step.
module tbpm_traceback #(
  parameter  int M          = 2,
  parameter  int TB_DEPTH   = 8,
  localparam int NUM_STATES = 2**M,
  localparam int CW         = $clog2(TB_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_STATES-1:0] dec_vec,
  input  logic [M-1:0]          best_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic                  out_last,
  output logic [CW-1:0]         fill_cnt,
  output logic                  busy
);

  localparam int PW = $clog2(TB_DEPTH);

  typedef enum logic {FILL, TRACE} state_e;

  state_e                state, state_nxt;
  logic [NUM_STATES-1:0] mem [TB_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [M-1:0]          cur_state;
  logic                  accept;
  logic                  last_vec;
  logic                  advance;

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    accept    = 1'b0;
    last_vec  = 1'b0;
    advance   = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        last_vec = in_valid && (fill_cnt == CW'(TB_DEPTH - 1));
        if (last_vec) state_nxt = TRACE;
      end
      TRACE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_bit   = cur_state[M-1];
        out_last  = (rd_ptr == '0);
        advance   = out_ready;
        if (out_ready && out_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Memory is deliberately left out of reset; a new block overwrites every column.
  always_ff @(posedge clk) begin
    if (accept) mem[fill_cnt[PW-1:0]] <= dec_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt  <= '0;
      rd_ptr    <= '0;
      cur_state <= '0;
    end else begin
      if (accept) fill_cnt <= fill_cnt + CW'(1);
      if (last_vec) begin
        cur_state <= best_state;
        rd_ptr    <= PW'(TB_DEPTH - 1);
      end
      if (advance) begin
        cur_state <= {cur_state[M-2:0], mem[rd_ptr][cur_state]};
        // Pointer stops at 0; the block ends on that handshake instead of wrapping.
        if (out_last) fill_cnt <= '0;
        else          rd_ptr   <= rd_ptr - PW'(1);
      end
    end
  end

endmodule
